// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone B4 timer: per-channel prescaler, compare/reload counter,
// one-shot or periodic mode, per-channel interrupt vector and a shared W1C status.
module wb_timer_multi #(
  parameter int NUM_CH          = 4,
  parameter int WIDTH           = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [3:0]        i_wb_sel,
  input  logic [5:0]        i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  output logic [31:0]       o_wb_dat,
  output logic              o_wb_ack,
  output logic              o_irq,
  output logic [NUM_CH-1:0] o_irq_vec
);
  localparam int         PW         = PRESCALER_WIDTH;
  localparam logic [5:0] STATUS_ADR = 6'h20;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COMPARE = 2'd1,
    REG_COUNTER = 2'd2,
    REG_RSVD    = 2'd3
  } reg_e;

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] oneshot;
  logic [PW-1:0]     prescaler [NUM_CH];
  logic [PW-1:0]     pcnt      [NUM_CH];
  logic [WIDTH-1:0]  compare   [NUM_CH];
  logic [WIDTH-1:0]  reload    [NUM_CH];
  logic [WIDTH-1:0]  counter   [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] match;

  logic              commit;
  logic              wr;
  logic              status_hit;
  reg_e              reg_sel;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] hit_cmp;
  logic [NUM_CH-1:0] clr_pend;
  logic [NUM_CH-1:0] clr_match;
  logic [31:0]       rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] dat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  // The ack flop doubles as the "already committed" flag, forcing a gap cycle.
  assign commit     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr         = commit & i_wb_we;
  assign status_hit = (i_wb_adr == STATUS_ADR);
  assign reg_sel    = reg_e'(i_wb_adr[1:0]);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ch_hit    = '0;
    restart   = '0;
    tick      = '0;
    hit_cmp   = '0;
    clr_pend  = '0;
    clr_match = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ch_hit[ch]    = ~i_wb_adr[5] & (i_wb_adr[4:2] == 3'(ch));
      restart[ch]   = wr & ch_hit[ch] & (reg_sel == REG_CTRL) & i_wb_sel[0] & i_wb_dat[3];
      // A restart write swallows that cycle's tick entirely.
      tick[ch]      = en[ch] & (pcnt[ch] >= prescaler[ch]) & ~restart[ch];
      hit_cmp[ch]   = tick[ch] & (counter[ch] == compare[ch]);
      clr_pend[ch]  = wr & status_hit & i_wb_sel[0] & i_wb_dat[ch];
      clr_match[ch] = wr & status_hit & i_wb_sel[1] & i_wb_dat[8+ch];
    end
  end

  always_comb begin
    rdata = '0;
    if (status_hit) begin
      rdata[NUM_CH-1:0]  = pending;
      rdata[8 +: NUM_CH] = match;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ch_hit[ch]) begin
        case (reg_sel)
          REG_CTRL: begin
            rdata[31:16] = 16'(prescaler[ch]);
            rdata[2:0]   = {oneshot[ch], irq_en[ch], en[ch]};
          end
          REG_COMPARE: rdata = 32'(compare[ch]);
          REG_COUNTER: rdata = 32'(counter[ch]);
          default:     rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
      en       <= '0;
      irq_en   <= '0;
      oneshot  <= '0;
      pending  <= '0;
      match    <= '0;
      // NOTE: the per-channel arrays are plain flops, not RAM, so every entry is reset explicitly.
      for (int ch = 0; ch < NUM_CH; ch++) begin
        prescaler[ch] <= '0;
        pcnt[ch]      <= '0;
        compare[ch]   <= '1;
        reload[ch]    <= '0;
        counter[ch]   <= '0;
      end
    end else begin
      o_wb_ack <= commit;
      o_wb_dat <= commit ? rdata : '0;
      // Set terms are ORed after the clear so a same-cycle match survives W1C.
      pending  <= (pending & ~clr_pend) | (hit_cmp & irq_en);
      match    <= (match & ~clr_match) | hit_cmp;

      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (restart[ch]) begin
          counter[ch] <= reload[ch];
          pcnt[ch]    <= '0;
        end else if (!en[ch]) begin
          pcnt[ch] <= '0;
        end else if (tick[ch]) begin
          pcnt[ch] <= '0;
          if (hit_cmp[ch]) begin
            counter[ch] <= reload[ch];
            if (oneshot[ch]) en[ch] <= 1'b0;
          end else begin
            counter[ch] <= counter[ch] + WIDTH'(1);
          end
        end else begin
          pcnt[ch] <= pcnt[ch] + PW'(1);
        end

        // NOTE: this write follows the one-shot clear above; the later non-blocking assignment to en wins.
        if (wr && ch_hit[ch]) begin
          case (reg_sel)
            REG_CTRL: begin
              if (i_wb_sel[0]) begin
                en[ch]      <= i_wb_dat[0];
                irq_en[ch]  <= i_wb_dat[1];
                oneshot[ch] <= i_wb_dat[2];
              end
              prescaler[ch] <= PW'(merge_bytes({16'(prescaler[ch]), 16'h0}, i_wb_dat, i_wb_sel) >> 16);
            end
            REG_COMPARE: compare[ch] <= WIDTH'(merge_bytes(32'(compare[ch]), i_wb_dat, i_wb_sel));
            REG_COUNTER: reload[ch]  <= WIDTH'(merge_bytes(32'(reload[ch]), i_wb_dat, i_wb_sel));
            default: ;
          endcase
        end
      end
    end
  end

  assign o_irq_vec = pending;
  assign o_irq     = |pending;

endmodule
